// File: rtl/cu_fsm_mem.sv
// ============================================================================
// cu_fsm_mem -- multi-cycle control unit FSM with memory handshake,
//               access timeout/retry, vectored interrupt entry and a
//               retired-instruction counter.
//
// State flow:
//   INIT -> FETCH -(mem_ready)-> EXEC -(load/store)-> MEM -(mem_ready)-> retire
//                                 EXEC -(other)-> retire
//   retire -> INTR (interrupt pending and mie) or FETCH
//   INTR   -> FETCH
//
// Parameters:
//   NUM_INT      number of interrupt sources (1..8)
//   MEM_TIMEOUT  wait cycles before an access is flagged and retried (2..255)
//   CNT_W        width of the retired-instruction counter
//
// Ports:
//   CLK        in   system clock, rising-edge active
//   RST_N      in   synchronous active-low reset
//   opcode     in   IR[6:0]
//   funct3     in   IR[14:12]
//   int_req    in   level-sensitive interrupt requests [NUM_INT]
//   int_en     in   per-source interrupt enables [NUM_INT]
//   mie        in   global interrupt enable
//   mem_ready  in   memory handshake; current access completes when 1
//   PC_WE      out  program counter write enable
//   RF_WE      out  register file write enable
//   CSR_WE     out  CSR file write enable
//   memRDEN1   out  instruction read strobe
//   memRDEN2   out  data read strobe
//   memWE2     out  data write strobe
//   int_taken  out  interrupt entry pulse
//   mret_exec  out  mret retire pulse
//   int_cause  out  index of the most recently taken interrupt source
//   mem_err    out  sticky memory timeout flag
//   instret    out  retired-instruction count (wraps)
// ============================================================================
module cu_fsm_mem #(
    parameter int NUM_INT     = 4,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic                                       CLK,
    input  logic                                       RST_N,
    input  logic [6:0]                                 opcode,
    input  logic [2:0]                                 funct3,
    input  logic [NUM_INT-1:0]                         int_req,
    input  logic [NUM_INT-1:0]                         int_en,
    input  logic                                       mie,
    input  logic                                       mem_ready,
    output logic                                       PC_WE,
    output logic                                       RF_WE,
    output logic                                       CSR_WE,
    output logic                                       memRDEN1,
    output logic                                       memRDEN2,
    output logic                                       memWE2,
    output logic                                       int_taken,
    output logic                                       mret_exec,
    output logic [((NUM_INT > 1) ? $clog2(NUM_INT) : 1)-1:0] int_cause,
    output logic                                       mem_err,
    output logic [CNT_W-1:0]                           instret
);

    localparam int CAUSE_W = (NUM_INT > 1) ? $clog2(NUM_INT) : 1;

    // Opcode map (RV32I major opcodes)
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // The timeout comparison happens on the last allowed wait cycle, so the
    // constant is one less than the configured timeout.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        INIT  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        MEM   = 3'd3,
        INTR  = 3'd4
    } state_t;

    state_t               state_reg, state_next;
    logic                 is_store_reg, is_store_next;
    logic [7:0]           wait_cnt_reg, wait_cnt_next;
    logic                 gap_reg, gap_next;
    logic                 mem_err_reg, mem_err_next;
    logic [CAUSE_W-1:0]   int_cause_reg, int_cause_next;
    logic [CNT_W-1:0]     instret_reg, instret_next;

    logic                 retire;
    logic                 access_wait;
    logic [NUM_INT-1:0]   pending;
    logic [CAUSE_W-1:0]   pending_idx;

    // ------------------------------------------------------------------
    // Interrupt pending vector and lowest-index priority select
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_INT; gi++) begin : g_pending
            assign pending[gi] = int_req[gi] & int_en[gi];
        end
    endgenerate

    always_comb begin
        pending_idx = '0;
        // Walk downwards so the lowest pending index is the one left standing.
        for (int i = NUM_INT - 1; i >= 0; i--) begin
            if (pending[i]) begin
                pending_idx = CAUSE_W'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Decode helpers for EXEC
    // ------------------------------------------------------------------
    logic is_mem_op;
    logic is_csr_rw;
    logic is_mret;
    logic is_rf_op;

    always_comb begin
        is_mem_op = (opcode == OP_LOAD) || (opcode == OP_STORE);
        is_csr_rw = (opcode == OP_SYSTEM) && (funct3 >= 3'b001) && (funct3 <= 3'b011);
        is_mret   = (opcode == OP_SYSTEM) && (funct3 == 3'b000);
        is_rf_op  = (opcode == OP_REG)  || (opcode == OP_IMM)   ||
                    (opcode == OP_LUI)  || (opcode == OP_AUIPC) ||
                    (opcode == OP_JAL)  || (opcode == OP_JALR);
    end

    // ------------------------------------------------------------------
    // Next-state and strobe logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        is_store_next = is_store_reg;
        PC_WE         = 1'b0;
        RF_WE         = 1'b0;
        CSR_WE        = 1'b0;
        memRDEN1      = 1'b0;
        memRDEN2      = 1'b0;
        memWE2        = 1'b0;
        int_taken     = 1'b0;
        mret_exec     = 1'b0;
        retire        = 1'b0;

        case (state_reg)
            INIT: begin
                state_next = FETCH;
            end

            FETCH: begin
                // During the post-timeout gap the strobe is dropped and any
                // mem_ready is meaningless, so nothing can complete.
                if (!gap_reg) begin
                    memRDEN1 = 1'b1;
                    if (mem_ready) begin
                        state_next = EXEC;
                    end
                end
            end

            EXEC: begin
                if (is_mem_op) begin
                    // Remember the access kind so MEM does not depend on the
                    // opcode staying stable.
                    is_store_next = (opcode == OP_STORE);
                    state_next    = MEM;
                end else begin
                    PC_WE     = 1'b1;
                    RF_WE     = is_rf_op || is_csr_rw;
                    CSR_WE    = is_csr_rw;
                    mret_exec = is_mret;
                    retire    = 1'b1;
                end
            end

            MEM: begin
                if (!gap_reg) begin
                    memWE2   = is_store_reg;
                    memRDEN2 = !is_store_reg;
                    if (mem_ready) begin
                        PC_WE  = 1'b1;
                        RF_WE  = !is_store_reg;
                        retire = 1'b1;
                    end
                end
            end

            INTR: begin
                int_taken  = 1'b1;
                PC_WE      = 1'b1;
                state_next = FETCH;
            end

            default: begin
                state_next = INIT;
            end
        endcase

        // Interrupts are only considered at the retire boundary.
        if (retire) begin
            state_next = (mie && (|pending)) ? INTR : FETCH;
        end
    end

    // ------------------------------------------------------------------
    // Wait counter, timeout/retry, sticky error, cause and instret
    // ------------------------------------------------------------------
    assign access_wait = ((state_reg == FETCH) || (state_reg == MEM)) &&
                         !gap_reg && !mem_ready;

    always_comb begin
        wait_cnt_next  = wait_cnt_reg;
        gap_next       = 1'b0;
        mem_err_next   = mem_err_reg;
        int_cause_next = int_cause_reg;
        instret_next   = instret_reg;

        if (access_wait) begin
            if (wait_cnt_reg == WAIT_LAST) begin
                // This cycle is the MEM_TIMEOUT-th without a handshake:
                // flag it, idle the strobe for one cycle and start over.
                mem_err_next  = 1'b1;
                gap_next      = 1'b1;
                wait_cnt_next = '0;
            end else begin
                wait_cnt_next = wait_cnt_reg + 8'd1;
            end
        end

        // Each new access starts with a fresh wait budget.
        if ((state_next != state_reg) &&
            ((state_next == FETCH) || (state_next == MEM))) begin
            wait_cnt_next = '0;
            gap_next      = 1'b0;
        end

        if ((state_next == INTR) && (state_reg != INTR)) begin
            int_cause_next = pending_idx;
        end

        if (retire) begin
            instret_next = instret_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_reg     <= INIT;
            is_store_reg  <= 1'b0;
            wait_cnt_reg  <= '0;
            gap_reg       <= 1'b0;
            mem_err_reg   <= 1'b0;
            int_cause_reg <= '0;
            instret_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            is_store_reg  <= is_store_next;
            wait_cnt_reg  <= wait_cnt_next;
            gap_reg       <= gap_next;
            mem_err_reg   <= mem_err_next;
            int_cause_reg <= int_cause_next;
            instret_reg   <= instret_next;
        end
    end

    assign int_cause = int_cause_reg;
    assign mem_err   = mem_err_reg;
    assign instret   = instret_reg;

endmodule
